seg_scan_ctrl: RTL and testbench

//   Time-multiplexed scan controller: one hc4511 BCD-to-7-seg decoder is shared across NDIG

---
 rtl/seg_scan_if.sv | 25 ++
 rtl/seg_scan_ctrl.sv | 133 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
// Bus between a scan controller and its user: the load handshake in, the decoder and digit drive out.
// The interface parameter NDIG must equal the NDIG of the controller that uses it.
interface seg_scan_if #(
    parameter int NDIG = 4
);
    logic              En;
    logic              LdReq;
    logic [4*NDIG-1:0] LdData;
    logic              LdAck;
    logic [3:0]        Bcd;
    logic              LE;
    logic              BI_N;
    logic [NDIG-1:0]   DigEn;
    logic              FrameTick;

    modport master (
        output En, LdReq, LdData,
        input  LdAck, Bcd, LE, BI_N, DigEn, FrameTick
    );

    modport slave (
        input  En, LdReq, LdData,
        output LdAck, Bcd, LE, BI_N, DigEn, FrameTick
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Scan controller: one shared hc4511 decoder multiplexed across NDIG common-cathode digits, with a
// frame-atomic shadow copy of the displayed value and optional leading-zero blanking.
module seg_scan_ctrl #(
    parameter int NDIG  = 4,
    parameter int DWELL = 1000,
    parameter int BLANK = 8,
    parameter int LZB   = 1
) (
    input  logic      CP,
    input  logic      MR,
    seg_scan_if.slave bus
);
    localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_ON} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [4*NDIG-1:0] shadow_q, shadow_d;
    logic              ld_ack_q, ld_ack_d;
    logic              frame_tick_q, frame_tick_d;
    logic [3:0]        bcd_q, bcd_d;
    logic              le_q, le_d;
    logic              bi_n_q, bi_n_d;
    logic [NDIG-1:0]   dig_en_q, dig_en_d;
    logic              last_on, frame_end;
    logic [NDIG-1:0]   upper_nz;

    // upper_nz[i]: digit i or some more significant digit is non-zero in the next shadow.
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_nz
        assign upper_nz[gi] = |shadow_d[4*NDIG-1:4*gi];
    end

    assign last_on   = (state_q == S_ON) && (cnt_q == CW'(DWELL - 1));
    assign frame_end = last_on && (idx_q == IW'(NDIG - 1));

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        shadow_d     = shadow_q;
        frame_tick_d = frame_end;
        ld_ack_d     = bus.LdReq && !ld_ack_q && ((state_q == S_IDLE) || frame_end);

        case (state_q)
            S_IDLE: begin
                if (bus.En) begin
                    state_d = S_BLANK;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_BLANK: begin
                if (cnt_q == CW'(BLANK - 1)) begin
                    state_d = S_ON;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ON: begin
                if (last_on) begin
                    cnt_d   = '0;
                    idx_d   = frame_end ? '0 : idx_q + IW'(1);
                    state_d = bus.En ? S_BLANK : S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (ld_ack_d) begin
            shadow_d = bus.LdData;
        end
    end

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    always_comb begin
        dig_en_d = '0;
        bi_n_d   = 1'b0;
        le_d     = 1'b1;
        bcd_d    = 4'd0;
        case (state_d)
            S_BLANK: begin
                bcd_d = shadow_d[{idx_d, 2'b00} +: 4];
                le_d  = (cnt_d != CW'(BLANK - 1));
            end
            S_ON: begin
                bcd_d    = shadow_d[{idx_d, 2'b00} +: 4];
                dig_en_d = NDIG'(1) << idx_d;
                bi_n_d   = !((LZB != 0) && (idx_d != '0) && !upper_nz[idx_d]);
            end
            default: ;
        endcase
    end

    always_ff @(posedge CP) begin
        if (MR) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            shadow_q     <= '0;
            ld_ack_q     <= 1'b0;
            frame_tick_q <= 1'b0;
            bcd_q        <= 4'd0;
            le_q         <= 1'b1;
            bi_n_q       <= 1'b0;
            dig_en_q     <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            ld_ack_q     <= ld_ack_d;
            frame_tick_q <= frame_tick_d;
            bcd_q        <= bcd_d;
            le_q         <= le_d;
            bi_n_q       <= bi_n_d;
            dig_en_q     <= dig_en_d;
        end
    end

    assign bus.LdAck     = ld_ack_q;
    assign bus.FrameTick = frame_tick_q;
    assign bus.Bcd       = bcd_q;
    assign bus.LE        = le_q;
    assign bus.BI_N      = bi_n_q;
    assign bus.DigEn     = dig_en_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random traffic, every cycle compared against a
// frame-position model (slot = k / (BLANK+DWELL), offset = k % (BLANK+DWELL)).
module tb_seg_scan_ctrl;
    localparam int NDIG  = 4;
    localparam int DWELL = 4;
    localparam int BLANK = 2;
    localparam int LZB   = 1;
    localparam int SLOT  = BLANK + DWELL;

    logic CP = 1'b0;
    logic MR;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    seg_scan_if #(.NDIG(NDIG)) bus ();

    seg_scan_ctrl #(.NDIG(NDIG), .DWELL(DWELL), .BLANK(BLANK), .LZB(LZB)) dut (
        .CP  (CP),
        .MR  (MR),
        .bus (bus)
    );

    always #5 CP = ~CP;

    // Reference model: scanning flag, position k within the frame, shadow, pulse outputs.
    bit          m_scan = 0;
    int          m_k    = 0;
    logic [15:0] m_shadow = '0;
    bit          m_ack = 0;
    bit          m_ft  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        bit cap, ft, last;
        int off, d;
        cap = 0;
        ft  = 0;
        if (MR) begin
            m_scan = 0; m_k = 0; m_shadow = '0; m_ack = 0; m_ft = 0;
        end else begin
            if (!m_scan) begin
                cap = bus.LdReq && !m_ack;
                if (bus.En) begin
                    m_scan = 1;
                    m_k    = 0;
                end
            end else begin
                off  = m_k % SLOT;
                d    = m_k / SLOT;
                last = (off == SLOT - 1);
                ft   = last && (d == NDIG - 1);
                cap  = bus.LdReq && !m_ack && ft;
                if (last && !bus.En) m_scan = 0;
                else m_k = (m_k + 1) % (NDIG * SLOT);
            end
            if (cap) m_shadow = bus.LdData;
            m_ack = cap;
            m_ft  = ft;
        end
    endtask

    task automatic check_all();
        logic [3:0] e_dig, e_bcd;
        logic       e_le, e_bi;
        int         off, d;
        e_dig = '0; e_bcd = '0; e_le = 1'b1; e_bi = 1'b0;
        if (m_scan) begin
            off   = m_k % SLOT;
            d     = m_k / SLOT;
            e_bcd = 4'((m_shadow >> (4 * d)) & 16'hF);
            if (off < BLANK) begin
                e_le = (off != BLANK - 1);
            end else begin
                e_dig = 4'(1 << d);
                e_bi  = !(LZB != 0 && d > 0 && (m_shadow >> (4 * d)) == 0);
            end
        end
        chk("DigEn", 32'(bus.DigEn), 32'(e_dig));
        chk("Bcd", 32'(bus.Bcd), 32'(e_bcd));
        chk("LE", 32'(bus.LE), 32'(e_le));
        chk("BI_N", 32'(bus.BI_N), 32'(e_bi));
        chk("LdAck", 32'(bus.LdAck), 32'(m_ack));
        chk("FrameTick", 32'(bus.FrameTick), 32'(m_ft));
    endtask

    task automatic cycle();
        @(posedge CP);
        model_update();
        cyc++;
        @(negedge CP);
        check_all();
    endtask

    task automatic wait_dig(input logic [3:0] pat, input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.DigEn === pat) begin
                ok = 1;
                break;
            end
            cycle();
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_ack(input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (bus.LdAck === 1'b1) begin
                ok = 1;
                break;
            end
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        int t0, t1;
        bit ok;
        MR = 1'b1; bus.En = 1'b0; bus.LdReq = 1'b0; bus.LdData = '0;
        @(negedge CP);
        cycle();
        cycle();
        chk("rst_DigEn", 32'(bus.DigEn), 32'd0);
        chk("rst_LE", 32'(bus.LE), 32'd1);
        chk("rst_Bcd", 32'(bus.Bcd), 32'd0);
        MR = 1'b0;
        cycle();

        // Idle load: ack one edge after the request is sampled, no re-capture while held.
        bus.LdReq = 1'b1; bus.LdData = 16'h1234;
        cycle();
        chk("idle_ack_hi", 32'(bus.LdAck), 32'd1);
        cycle();
        chk("idle_ack_lo", 32'(bus.LdAck), 32'd0);
        bus.LdReq = 1'b0;
        cycle();

        // Scan 1234: frame period check.
        bus.En = 1'b1;
        for (int n = 0; n < 2; n++) begin
            ok = 0;
            for (int i = 0; i < 60; i++) begin
                cycle();
                if (bus.FrameTick === 1'b1) begin
                    ok = 1;
                    break;
                end
            end
            chk("ft_seen", 32'(ok), 32'd1);
            if (n == 0) t0 = cyc; else t1 = cyc;
        end
        chk("ft_period", 32'(t1 - t0), 32'd24);
        wait_dig(4'b1000, "wait_d3");
        chk("d3_Bcd", 32'(bus.Bcd), 32'd1);

        // Boundary load issued mid-digit-1.
        wait_dig(4'b0010, "wait_d1");
        bus.LdReq = 1'b1; bus.LdData = 16'h0056;
        wait_ack("bnd_ack");
        chk("bnd_ack_ft", 32'(bus.FrameTick), 32'd1);
        bus.LdReq = 1'b0;
        wait_dig(4'b1000, "wait_lz3");
        chk("lz3_BI_N", 32'(bus.BI_N), 32'd0);
        wait_dig(4'b0010, "wait_lz1");
        chk("lz1_Bcd", 32'(bus.Bcd), 32'd5);
        bus.LdReq = 1'b1; bus.LdData = 16'h0000;
        wait_ack("zero_ack");
        bus.LdReq = 1'b0;
        wait_dig(4'b0001, "wait_z0");
        chk("z0_BI_N", 32'(bus.BI_N), 32'd1);
        for (int i = 0; i < 2 * SLOT; i++) cycle();

        // En drop during the 2nd ON cycle of digit 1.
        bus.LdReq = 1'b1; bus.LdData = 16'h4321;
        wait_ack("ld4321_ack");
        bus.LdReq = 1'b0;
        wait_dig(4'b0010, "wait_en_d1");
        cycle();
        bus.En = 1'b0;
        cycle();
        cycle();
        chk("en_drop_dwell", 32'(bus.DigEn), 32'b0010);
        cycle();
        chk("en_drop_idle", 32'(bus.DigEn), 32'd0);
        for (int i = 0; i < 4; i++) cycle();
        bus.En = 1'b1;
        wait_dig(4'b0001, "restart_d0");
        chk("restart_Bcd", 32'(bus.Bcd), 32'd1);

        // Reset mid-frame with a pending request.
        wait_dig(4'b0100, "wait_mr_d2");
        bus.LdReq = 1'b1; bus.LdData = 16'h9999; MR = 1'b1;
        cycle();
        chk("mr_DigEn", 32'(bus.DigEn), 32'd0);
        chk("mr_LdAck", 32'(bus.LdAck), 32'd0);
        bus.LdReq = 1'b0; MR = 1'b0;
        cycle();
        wait_dig(4'b0001, "mr_restart");
        chk("mr_shadow0", 32'(bus.Bcd), 32'd0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            if (bus.LdReq && bus.LdAck) bus.LdReq = 1'b0;
            else if (!bus.LdReq && $urandom_range(0, 15) == 0) begin
                bus.LdReq = 1'b1;
                for (int j = 0; j < NDIG; j++)
                    bus.LdData[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 40) == 0) bus.En = ~bus.En;
            MR = ($urandom_range(0, 400) == 0);
            if (MR) bus.LdReq = 1'b0;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
